// File: rtl/div_pkg.sv
// Shared types and default widths for the iterative restoring divider.
package div_pkg;
    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   p_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   p_o,
    output logic                 q_o
);
    // The incoming remainder is always below the divisor, so its top bit is zero and can be dropped.
    logic [DIVISOR_W:0] shifted_s;
    logic [DIVISOR_W:0] divisor_ext_s;

    assign shifted_s     = {p_i[DIVISOR_W-1:0], bit_i};
    assign divisor_ext_s = {1'b0, divisor_i};

    // Compare and conditionally subtract.
    always_comb begin
        p_o = shifted_s;
        q_o = 1'b0;
        if (shifted_s >= divisor_ext_s) begin
            p_o = shifted_s - divisor_ext_s;
            q_o = 1'b1;
        end else begin
            p_o = shifted_s;
            q_o = 1'b0;
        end
    end
endmodule

// File: rtl/sequential_divider.sv
// Iterative unsigned divider with valid/ready request and result handshakes, one quotient bit per cycle.
module sequential_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = div_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = div_pkg::DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] in1,
    input  logic [DIVISOR_W-1:0]  in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quot,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  dbz
);
    localparam int             LCNT_W   = $clog2(DIVIDEND_W + 1);
    localparam logic [LCNT_W-1:0] CNT_ONE  = LCNT_W'(1);
    localparam logic [LCNT_W-1:0] CNT_LAST = LCNT_W'(DIVIDEND_W - 1);

    div_state_e            state_q;
    logic [LCNT_W-1:0]     count_q;
    logic [DIVIDEND_W-1:0] dvd_q;
    logic [DIVISOR_W-1:0]  div_q;
    logic [DIVISOR_W:0]    p_q;
    logic                  dbz_pend_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [DIVIDEND_W-1:0] quot_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic                  dbz_q;

    logic [DIVISOR_W:0]    p_d;
    logic                  quot_bit_d;
    logic [DIVIDEND_W-1:0] dvd_d;

    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .p_i       (p_q),
        .bit_i     (dvd_q[DIVIDEND_W-1]),
        .divisor_i (div_q),
        .p_o       (p_d),
        .q_o       (quot_bit_d)
    );

    // Dividend bits leave at the MSB while quotient bits enter at the LSB of the same register.
    assign dvd_d = {dvd_q[DIVIDEND_W-2:0], quot_bit_d};

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            dvd_q       <= '0;
            div_q       <= '0;
            p_q         <= '0;
            dbz_pend_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q      <= in1;
                        div_q      <= in2;
                        p_q        <= '0;
                        count_q    <= '0;
                        dbz_pend_q <= (in2 == {DIVISOR_W{1'b0}});
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                // A zero divisor spends a single cycle here so its result appears one cycle after accept.
                BUSY: begin
                    if (dbz_pend_q) begin
                        quot_q      <= '1;
                        rem_q       <= '0;
                        dbz_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        p_q     <= p_d;
                        dvd_q   <= dvd_d;
                        count_q <= count_q + CNT_ONE;
                        if (count_q == CNT_LAST) begin
                            quot_q      <= dvd_d;
                            rem_q       <= p_d[DIVISOR_W-1:0];
                            dbz_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign dbz       = dbz_q;
endmodule

// File: tb/tb_sequential_divider.sv
// Directed and randomized checks of sequential_divider results, latency, back-pressure and reset.
module tb_sequential_divider;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in1;
    logic [7:0]  in2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quot;
    logic [7:0]  rem;
    logic        dbz;

    int checks = 0;
    int errors = 0;

    sequential_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request, check latency and result, optionally stall the result for 'hold' cycles.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                          input logic [7:0] er, input logic ed, input int lat, input int hold,
                          input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in1 = a; in2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in1 = ~a; in2 = b ^ 8'h5A;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(lat));
        check({tag, ".quot"}, 32'(quot), 32'(eq));
        check({tag, ".rem"}, 32'(rem), 32'(er));
        check({tag, ".dbz"}, 32'(dbz), 32'(ed));
        for (int k = 0; k < hold; k++) begin
            in_valid = (k % 2 == 0);
            in1 = 16'(k * 97 + 3); in2 = 8'(k + 1);
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_quot"}, 32'(quot), 32'(eq));
            check({tag, ".hold_rem"}, 32'(rem), 32'(er));
            check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [15:0] rq;
        logic [7:0]  rr;
        int          seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.quot", 32'(quot), 32'd0);
        check("reset.rem", 32'(rem), 32'd0);
        check("reset.dbz", 32'(dbz), 32'd0);

        run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 0, "div1000_7");
        run_op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16, 0, "div65535_255");
        run_op(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 16, 0, "div65535_1");
        run_op(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 16, 0, "div5_9");
        run_op(16'd0, 8'd3, 16'd0, 8'd0, 1'b0, 16, 0, "div0_3");
        run_op(16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1, 0, "dbz1234");
        run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 10, "backpressure");
        run_op(16'd50000, 8'd123, 16'd406, 8'd62, 1'b0, 16, 0, "div50000_123");

        // Reset in the middle of 200/13.
        in1 = 16'd200; in2 = 8'd13; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset.out_valid", 32'(out_valid), 32'd0);
        check("midreset.in_ready", 32'(in_ready), 32'd1);
        check("midreset.quot", 32'(quot), 32'd0);
        check("midreset.rem", 32'(rem), 32'd0);
        check("midreset.dbz", 32'(dbz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midreset.no_result", 32'(seen), 32'd0);
        run_op(16'd200, 8'd13, 16'd15, 8'd5, 1'b0, 16, 0, "after_reset");

        // Random operations with random result stalls, checked against reference division.
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = (i % 37 == 0) ? 8'd0 : 8'($urandom);
            if (rb == 8'd0) begin
                rq = 16'hFFFF; rr = 8'd0;
            end else begin
                rq = ra / {8'd0, rb};
                rr = 8'(ra % {8'd0, rb});
            end
            run_op(ra, rb, rq, rr, (rb == 8'd0), (rb == 8'd0) ? 1 : 16,
                   int'($urandom_range(0, 3)), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
